// File: rtl/rx_nibble_fifo.sv
// Serial-bit to nibble packer feeding a DEPTH-entry nibble FIFO.
// Define RX_NIBBLE_FIFO_SFD_EN to hold off packing until the 8'hA7 start delimiter is seen.
module rx_nibble_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     inClock,
  input  logic                     inReset,
  input  logic                     inWriteEnable,
  input  logic                     inData,
  input  logic                     inReadEnable,
  output logic [3:0]               outData,
  output logic                     outDone,
  output logic                     outFull,
  output logic                     outEmpty,
  output logic [$clog2(DEPTH):0]   outCount,
  output logic                     outWriteError,
  output logic                     outReadError
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    bit_cnt;
  logic [2:0]    partial;
  logic [3:0]    mem [DEPTH];

  logic          pack_en;
  logic          accept;
  logic          nibble_done;
  logic [3:0]    nibble;
  logic          pop;
  logic          push;

`ifdef RX_NIBBLE_FIFO_SFD_EN
  typedef enum logic {HUNT, PACK} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] hunt;
  logic [7:0] hunt_shifted;

  assign hunt_shifted = {inData, hunt[7:1]};

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) state <= HUNT;
    else          state <= state_nxt;
  end

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset)                             hunt <= 8'h00;
    else if (inWriteEnable && state == HUNT)  hunt <= hunt_shifted;
  end

  // NOTE: assign a default before the case so every path drives state_nxt; otherwise a latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      HUNT: if (inWriteEnable && hunt_shifted == 8'hA7) state_nxt = PACK;
      PACK: state_nxt = PACK;
    endcase
  end

  always_comb begin
    pack_en = (state == PACK);
  end
`else
  assign pack_en = 1'b1;
`endif

  assign accept      = inWriteEnable && pack_en;
  assign nibble_done = accept && (bit_cnt == 2'd3);
  assign nibble      = {inData, partial};

  assign outFull  = (count == CW'(DEPTH));
  assign outEmpty = (count == '0);
  assign outCount = count;

  // A full FIFO still takes a push when a pop frees a slot on the same edge.
  assign pop  = inReadEnable && !outEmpty;
  assign push = nibble_done && (!outFull || pop);

  // Earlier bits shift down so the first accepted bit ends up at bit 0.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      bit_cnt <= 2'd0;
      partial <= 3'd0;
    end else if (accept) begin
      bit_cnt <= bit_cnt + 2'd1;
      partial <= {inData, partial[2:1]};
    end
  end

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; entries are only observed after being written, and omitting reset keeps it RAM-mappable.
  always_ff @(posedge inClock) begin
    if (push) mem[wr_ptr] <= nibble;
  end

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      outData       <= 4'h0;
      outDone       <= 1'b0;
      outWriteError <= 1'b0;
      outReadError  <= 1'b0;
    end else begin
      if (pop) outData <= mem[rd_ptr];
      outDone       <= pop;
      outWriteError <= nibble_done && outFull && !pop;
      outReadError  <= inReadEnable && outEmpty;
    end
  end

endmodule

// File: tb/tb_rx_nibble_fifo.sv
// Self-checking bench for rx_nibble_fifo: directed scenarios plus random traffic against a queue model.
// Covers the start-delimiter hunt as well when RX_NIBBLE_FIFO_SFD_EN is defined.
module tb_rx_nibble_fifo;

  localparam int DEPTH = 8;
`ifdef RX_NIBBLE_FIFO_SFD_EN
  localparam bit SFD = 1'b1;
`else
  localparam bit SFD = 1'b0;
`endif

  logic       inClock = 1'b0;
  logic       inReset = 1'b0;
  logic       inWriteEnable = 1'b0;
  logic       inData = 1'b0;
  logic       inReadEnable = 1'b0;
  logic [3:0] outData;
  logic       outDone;
  logic       outFull;
  logic       outEmpty;
  logic [3:0] outCount;
  logic       outWriteError;
  logic       outReadError;

  always #5 inClock = ~inClock;

  rx_nibble_fifo #(.DEPTH(DEPTH)) dut (
    .inClock       (inClock),
    .inReset       (inReset),
    .inWriteEnable (inWriteEnable),
    .inData        (inData),
    .inReadEnable  (inReadEnable),
    .outData       (outData),
    .outDone       (outDone),
    .outFull       (outFull),
    .outEmpty      (outEmpty),
    .outCount      (outCount),
    .outWriteError (outWriteError),
    .outReadError  (outReadError)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of nibbles, a list of pending bits, and the last 8 hunted bits.
  logic [3:0] q[$];
  bit         hist[$];
  logic [3:0] partial = 4'h0;
  int         nbits = 0;
  logic [3:0] m_data = 4'h0;
  logic       m_done = 1'b0;
  logic       m_werr = 1'b0;
  logic       m_rerr = 1'b0;
  bit         m_pack = !SFD;
  logic [7:0] sfd_pat = 8'hA7;

  function automatic bit sfd_match();
    if (hist.size() != 8) return 1'b0;
    for (int i = 0; i < 8; i++)
      if (hist[i] != sfd_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge inClock or negedge inReset) begin
    bit         have_nib;
    logic [3:0] nib;
    if (!inReset) begin
      q.delete();
      hist.delete();
      partial = 4'h0;
      nbits   = 0;
      m_data  = 4'h0;
      m_done  = 1'b0;
      m_werr  = 1'b0;
      m_rerr  = 1'b0;
      m_pack  = !SFD;
    end else begin
      have_nib = 1'b0;
      nib      = 4'h0;
      m_done   = 1'b0;
      m_werr   = 1'b0;
      m_rerr   = 1'b0;
      if (inWriteEnable) begin
        if (m_pack) begin
          partial[nbits] = inData;
          nbits++;
          if (nbits == 4) begin
            have_nib = 1'b1;
            nib      = partial;
            nbits    = 0;
          end
        end else begin
          hist.push_back(inData);
          if (hist.size() > 8) void'(hist.pop_front());
          if (sfd_match()) m_pack = 1'b1;
        end
      end
      if (inReadEnable) begin
        if (q.size() == 0) m_rerr = 1'b1;
        else begin
          m_data = q.pop_front();
          m_done = 1'b1;
        end
      end
      if (have_nib) begin
        if (q.size() < DEPTH) q.push_back(nib);
        else                  m_werr = 1'b1;
      end
    end
  end

  always @(negedge inClock) begin
    check("cmp_data",  32'(outData),       32'(m_data));
    check("cmp_done",  32'(outDone),       32'(m_done));
    check("cmp_werr",  32'(outWriteError), 32'(m_werr));
    check("cmp_rerr",  32'(outReadError),  32'(m_rerr));
    check("cmp_count", 32'(outCount),      32'(q.size()));
    check("cmp_full",  32'(outFull),       32'(q.size() == DEPTH));
    check("cmp_empty", 32'(outEmpty),      32'(q.size() == 0));
  end

  task automatic step(input logic we, input logic d, input logic re);
    inWriteEnable = we;
    inData        = d;
    inReadEnable  = re;
    @(posedge inClock);
    #1;
  endtask

  task automatic send_nib(input logic [3:0] n);
    for (int i = 0; i < 4; i++) step(1'b1, n[i], 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  32'(outData),       32'h0);
    check({tag, "_done"},  32'(outDone),       32'h0);
    check({tag, "_full"},  32'(outFull),       32'h0);
    check({tag, "_empty"}, 32'(outEmpty),      32'h1);
    check({tag, "_count"}, 32'(outCount),      32'h0);
    check({tag, "_werr"},  32'(outWriteError), 32'h0);
    check({tag, "_rerr"},  32'(outReadError),  32'h0);
  endtask

  // Feeds the start delimiter in SFD builds; nothing may be stored while hunting.
  task automatic sync_sfd();
`ifdef RX_NIBBLE_FIFO_SFD_EN
    bit pat[12] = '{1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 0, 1};
    for (int i = 0; i < 12; i++) begin
      step(1'b1, pat[i], 1'b0);
      check("sfd_no_push", 32'(outCount), 32'h0);
    end
`endif
  endtask

  initial begin
    inReset = 1'b0;
    repeat (3) @(posedge inClock);
    #1;
    check_reset_outputs("rst");
    inReset = 1'b1;

    // Read while empty straight after reset.
    step(1'b0, 1'b0, 1'b1);
    check("empty_rd_rerr", 32'(outReadError), 32'h1);
    check("empty_rd_data", 32'(outData),      32'h0);
    check("empty_rd_done", 32'(outDone),      32'h0);
    step(1'b0, 1'b0, 1'b0);
    check("empty_rd_rerr_clr", 32'(outReadError), 32'h0);

    sync_sfd();
`ifdef RX_NIBBLE_FIFO_SFD_EN
    send_nib(4'h6);
    check("sfd_count", 32'(outCount), 32'h1);
    step(1'b0, 1'b0, 1'b1);
    check("sfd_data", 32'(outData), 32'h6);
    check("sfd_done", 32'(outDone), 32'h1);
`endif

    // Bits 1,0,1,1 pack LSB-first into 4'hD.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("pack_count_pre", 32'(outCount), 32'h0);
    step(1'b1, 1'b1, 1'b0);
    check("pack_count", 32'(outCount), 32'h1);
    step(1'b0, 1'b0, 1'b1);
    check("pack_data", 32'(outData), 32'hD);
    check("pack_done", 32'(outDone), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    check("pack_done_clr", 32'(outDone), 32'h0);

    // Nine pushes into eight slots, then drain.
    for (int k = 1; k <= 8; k++) begin
      send_nib(4'(k));
      check("fill_werr", 32'(outWriteError), 32'h0);
    end
    check("fill_full",  32'(outFull),  32'h1);
    check("fill_count", 32'(outCount), 32'h8);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("ovf_werr", 32'(outWriteError), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    check("ovf_werr_clr", 32'(outWriteError), 32'h0);
    check("ovf_count",    32'(outCount),      32'h8);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 1'b1);
      check("drain_data", 32'(outData), 32'(k));
      check("drain_done", 32'(outDone), 32'h1);
    end
    step(1'b0, 1'b0, 1'b0);
    check("drain_empty", 32'(outEmpty), 32'h1);

    // Full FIFO: 4th bit lands together with a read, so both succeed.
    for (int k = 0; k < 8; k++) send_nib(4'(k + 5));
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("fullrw_werr",  32'(outWriteError), 32'h0);
    check("fullrw_count", 32'(outCount),      32'h8);
    check("fullrw_data",  32'(outData),       32'h5);
    check("fullrw_done",  32'(outDone),       32'h1);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 1'b1);
      check("fullrw_drain", 32'(outData), (k < 8) ? 32'(k + 5) : 32'hB);
    end

    // Random traffic: write-heavy then read-heavy, with one mid-stream reset.
    for (int phase = 0; phase < 4; phase++) begin
      int rd_pct;
      rd_pct = (phase % 2 == 0) ? 8 : 45;
      for (int c = 0; c < 600; c++)
        step($urandom_range(0, 99) < 75, 1'($urandom), $urandom_range(0, 99) < rd_pct);
      if (phase == 1) begin
        inReset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        inReset = 1'b1;
        sync_sfd();
      end
    end

    // Reset mid-nibble discards the partial bits.
    step(1'b0, 1'b0, 1'b0);
    inReset = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    inReset = 1'b1;
    sync_sfd();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #2;
    inReset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge inClock);
    #1;
    inReset = 1'b1;
    sync_sfd();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("midrst_count", 32'(outCount), 32'h1);
    step(1'b0, 1'b0, 1'b1);
    check("midrst_data", 32'(outData), 32'h8);
    check("midrst_done", 32'(outDone), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_nibble_fifo.md
RX_NIBBLE_FIFO -- requirements
Module: rx_nibble_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO depth in nibbles (power of two, >= 2).
REQ-002 The block SHALL have port inClock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port inReset, input, 1, meaning the asynchronous, active-low reset.
REQ-004 The block SHALL have port inWriteEnable, input, 1, meaning the strobe that qualifies inData (CDR flag).
REQ-005 The block SHALL have port inData, input, 1, meaning the recovered serial bit (CDR data).
REQ-006 The block SHALL have port inReadEnable, input, 1, meaning the nibble read request.
REQ-007 The block SHALL have port outData, output, 4, meaning the last nibble read.
REQ-008 The block SHALL have port outDone, output, 1, meaning a one-cycle pulse when outData is updated.
REQ-009 The block SHALL have ports outFull and outEmpty, output, 1 each, meaning count==DEPTH and count==0.
REQ-010 The block SHALL have port outCount, output, $clog2(DEPTH)+1, meaning the stored nibble count.
REQ-011 The block SHALL have ports outWriteError and outReadError, output, 1 each, meaning one-cycle overflow and underflow pulses.

Function
REQ-012 On a cycle with inWriteEnable=1, the block SHALL accept inData as one bit; cycles with inWriteEnable=0 are ignored.
REQ-013 Bit packing SHALL be LSB-first: the 1st accepted bit of a nibble goes to bit 0 and the 4th to bit 3.
REQ-014 On acceptance of the 4th bit, the nibble SHALL be pushed into the FIFO in the same edge; the bit counter wraps 3->0.
REQ-015 A push while full and without a simultaneous accepted read SHALL drop the nibble, leave FIFO state unchanged, and pulse outWriteError for one cycle.
REQ-016 When inReadEnable=1 and the FIFO is not empty, the block SHALL pop the oldest nibble into outData on that edge and pulse outDone the next cycle (outDone is registered together with outData).
REQ-017 When inReadEnable=1 and the FIFO is empty, the block SHALL pulse outReadError for one cycle; outData SHALL hold its value and outDone SHALL stay 0.
REQ-018 On a simultaneous push and pop, both SHALL complete and outCount SHALL stay unchanged; when full, the push SHALL be accepted with no error.
REQ-019 On a simultaneous push and read while empty, the push SHALL complete, the read SHALL be an underflow, and no bypass SHALL occur.
REQ-020 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-021 outFull, outEmpty and outCount SHALL be derived from registered state with no combinational path from any input.

Reset
REQ-022 While inReset=0, the block SHALL asynchronously clear pointers, count, bit counter, shift registers and outData to 0, and set outEmpty=1, outFull=0, outDone=0, outWriteError=0, outReadError=0.
REQ-023 A reset asserted mid-nibble SHALL discard the partial bits; packing SHALL restart at bit 0 after release.
REQ-024 The first edge after reset release SHALL be able to accept a bit.

Configuration
REQ-025 With RX_NIBBLE_FIFO_SFD_EN defined, the block SHALL contain a two-state FSM {HUNT, PACK} that enters HUNT at reset.
REQ-026 In HUNT, accepted bits SHALL shift into an 8-bit register, with the new bit entering bit 7 and the register shifting right.
REQ-027 In HUNT, no nibbles SHALL be pushed.
REQ-028 The FSM SHALL go HUNT->PACK on the edge where the register equals 8'hA7; the next accepted bit SHALL be bit 0 of the first nibble.
REQ-029 PACK SHALL be left only by reset.
REQ-030 Without RX_NIBBLE_FIFO_SFD_EN, no FSM or hunt register SHALL exist, and packing SHALL start with the first accepted bit after reset.

Verification
REQ-031 Bench SHALL cover, macro off: bits 1,0,1,1 with inWriteEnable=1 -> outCount=1; a read then gives outData=4'hD and one outDone pulse.
REQ-032 Bench SHALL cover a 9-nibble push (DEPTH=8) with no reads -> outFull=1 after the 8th push, outWriteError pulses once on the 9th, and 8 reads return nibbles 1-8 in order.
REQ-033 Bench SHALL cover a read while empty after reset -> outReadError pulses once, outData=4'h0, outDone=0.
REQ-034 Bench SHALL cover, while full, a 4th bit accepted in the same cycle as inReadEnable=1 -> no outWriteError, outCount stays 8, and the oldest nibble is output.
REQ-035 Bench SHALL cover inReset pulsed low after 2 bits of a nibble -> all outputs return to reset values, and the next 4 bits 0,0,0,1 read back as 4'h8.
REQ-036 Bench SHALL cover, macro on: bits 1,1,0,0,1,1,1,0,0,1,0,1 then 0,1,1,0 -> no push before the SFD completes, then exactly one nibble 4'h6 is stored.
